// File: rtl/prog_clock_divider_if.sv
// Configuration write channel for prog_clock_divider: one shadow write per
// accepted transfer, with a registered error pulse for illegal requests.
interface prog_clock_divider_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic [WIDTH-1:0] cfg_high;
  logic             cfg_mode;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_mode,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_mode,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider. Each channel runs a period counter
// and emits a duty-cycled clock or a one-cycle pulse; new settings land on a wrap.
module prog_clock_divider #(
  parameter int NCH     = 4,
  parameter int WIDTH   = 32,
  parameter int DEF_DIV = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NCH-1:0]      ch_en,
  prog_clock_divider_if.slave cfg,
  output logic [NCH-1:0]      clk_out,
  output logic [NCH-1:0]      tick
);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NSLOT = 1 << CH_W;
  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEF_DIV / 2);

  logic [WIDTH-1:0] act_div  [NCH];
  logic [WIDTH-1:0] act_high [NCH];
  logic [WIDTH-1:0] sh_div   [NCH];
  logic [WIDTH-1:0] sh_high  [NCH];
  logic [WIDTH-1:0] cnt      [NCH];
  logic [NCH-1:0]   act_mode;
  logic [NCH-1:0]   sh_mode;
  logic [NCH-1:0]   pending;

  logic [NCH-1:0]   run;
  logic [NCH-1:0]   wrap;
  logic [NCH-1:0]   load;
  logic [NCH-1:0]   wr_hit;

  logic [NSLOT-1:0] pend_slot;
  logic [NSLOT-1:0] ch_exists;
  logic [WIDTH-1:0] div_m1;
  logic             ready;
  logic             accept;
  logic             ch_ok;
  logic             div_ok;
  logic             high_ok;
  logic             cfg_legal;
  logic             err_q;

  // Pad per-channel flags to the full cfg_ch range so out-of-range channel
  // numbers read as "not pending" and "does not exist".
  always_comb begin
    pend_slot = '0;
    pend_slot[NCH-1:0] = pending;
    ch_exists = '0;
    ch_exists[NCH-1:0] = '1;
  end

  assign ready         = ~pend_slot[cfg.cfg_ch];
  assign cfg.cfg_ready = ready;
  assign cfg.cfg_err   = err_q;
  assign accept        = cfg.cfg_valid & ready;

  assign div_m1    = cfg.cfg_div - WIDTH'(1);
  assign ch_ok     = ch_exists[cfg.cfg_ch];
  assign div_ok    = cfg.cfg_div >= WIDTH'(2);
  assign high_ok   = cfg.cfg_mode | ((cfg.cfg_high != '0) & (cfg.cfg_high <= div_m1));
  assign cfg_legal = ch_ok & div_ok & high_ok;

  // load: shadow becomes active, either on a wrap or as soon as the channel
  // is idled; a write accepted on a wrap edge only sets pending, so it waits
  // for the next wrap.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      run[i]    = en & ch_en[i];
      wrap[i]   = run[i] & (cnt[i] == act_div[i] - WIDTH'(1));
      load[i]   = pending[i] & (wrap[i] | (en & ~ch_en[i]));
      wr_hit[i] = accept & cfg_legal & (cfg.cfg_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        act_div[i]  <= DEF_P;
        act_high[i] <= DEF_H;
        sh_div[i]   <= DEF_P;
        sh_high[i]  <= DEF_H;
        cnt[i]      <= '0;
      end
      act_mode <= '0;
      sh_mode  <= '0;
      pending  <= '0;
      clk_out  <= '0;
      tick     <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= accept & ~cfg_legal;
      for (int i = 0; i < NCH; i++) begin
        if (load[i]) begin
          act_div[i]  <= sh_div[i];
          act_high[i] <= sh_high[i];
          act_mode[i] <= sh_mode[i];
          pending[i]  <= 1'b0;
        end else if (wr_hit[i]) begin
          sh_div[i]   <= cfg.cfg_div;
          sh_high[i]  <= cfg.cfg_high;
          sh_mode[i]  <= cfg.cfg_mode;
          pending[i]  <= 1'b1;
        end

        // Outputs present the counter position the edge consumed, so the
        // cycle after the first running edge shows cnt=0.
        if (!en) begin
          tick[i] <= 1'b0;
        end else if (!ch_en[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
        end else begin
          tick[i]    <= (cnt[i] == '0);
          clk_out[i] <= act_mode[i] ? (cnt[i] == '0) : (cnt[i] < act_high[i]);
          cnt[i]     <= wrap[i] ? '0 : cnt[i] + WIDTH'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider: a per-cycle vector table followed by
// hand-written sequences for wrap-coincident writes, disable-apply and reset.
module tb_prog_clock_divider;
  localparam int NCH   = 3;
  localparam int WIDTH = 8;

  typedef struct {
    logic       en;
    logic       valid;
    logic [1:0] ch;
    logic [7:0] div;
    logic [7:0] high;
    logic       mode;
    logic [2:0] exp_clk;
    logic [2:0] exp_tick;
    logic       exp_err;
    logic       exp_rdy;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           en    = 1'b1;
  logic [NCH-1:0] ch_en = 3'b011;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  prog_clock_divider_if #(.NCH(NCH), .WIDTH(WIDTH)) cfg_if ();

  prog_clock_divider #(.NCH(NCH), .WIDTH(WIDTH), .DEF_DIV(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .ch_en   (ch_en),
    .cfg     (cfg_if.slave),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add(input int e, input int v, input int c, input int d, input int h,
                     input int m, input int ec, input int et, input int er, input int rd);
    vec_t r;
    r.en = 1'(e); r.valid = 1'(v); r.ch = 2'(c); r.div = 8'(d); r.high = 8'(h);
    r.mode = 1'(m); r.exp_clk = 3'(ec); r.exp_tick = 3'(et);
    r.exp_err = 1'(er); r.exp_rdy = 1'(rd);
    tbl.push_back(r);
  endtask

  task automatic cyc(input int e, input int ce, input int v, input int c,
                     input int d, input int h, input int m);
    en               = 1'(e);
    ch_en            = 3'(ce);
    cfg_if.cfg_valid = 1'(v);
    cfg_if.cfg_ch    = 2'(c);
    cfg_if.cfg_div   = 8'(d);
    cfg_if.cfg_high  = 8'(h);
    cfg_if.cfg_mode  = 1'(m);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] exp_t;
    logic [9:0] exp_c;
    logic [3:0] exp_p;
    logic [2:0] e_clk;
    logic [2:0] e_tick;

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_high  = '0;
    cfg_if.cfg_mode  = 1'b0;

    // Row n is edge n after reset release; channel 2 stays disabled.
    add(1,0,0,0,0,0,'b011,'b011,0,1);                  // E1
    repeat (4) add(1,0,0,0,0,0,'b011,'b000,0,1);       // E2-E5
    repeat (5) add(1,0,0,0,0,0,'b000,'b000,0,1);       // E6-E10
    add(1,0,0,0,0,0,'b011,'b011,0,1);                  // E11
    add(1,0,0,0,0,0,'b011,'b000,0,1);                  // E12
    add(1,1,0,4,1,0,'b011,'b000,0,0);                  // E13 ch0 P4 H1
    repeat (2) add(1,0,0,0,0,0,'b011,'b000,0,0);       // E14-E15
    repeat (4) add(1,0,0,0,0,0,'b000,'b000,0,0);       // E16-E19
    add(1,0,0,0,0,0,'b000,'b000,0,1);                  // E20 wrap applies
    add(1,0,0,0,0,0,'b011,'b011,0,1);                  // E21
    repeat (3) add(1,0,0,0,0,0,'b010,'b000,0,1);       // E22-E24
    add(1,0,0,0,0,0,'b011,'b001,0,1);                  // E25
    add(1,1,1,3,0,1,'b000,'b000,0,0);                  // E26 ch1 P3 pulse
    repeat (2) add(1,0,1,0,0,0,'b000,'b000,0,0);       // E27-E28
    add(1,0,1,0,0,0,'b001,'b001,0,0);                  // E29
    add(1,0,1,0,0,0,'b000,'b000,0,1);                  // E30 ch1 wrap
    add(1,0,1,0,0,0,'b010,'b010,0,1);                  // E31
    add(1,0,1,0,0,0,'b000,'b000,0,1);                  // E32
    add(1,0,1,0,0,0,'b001,'b001,0,1);                  // E33
    add(1,0,1,0,0,0,'b010,'b010,0,1);                  // E34
    repeat (2) add(1,0,1,0,0,0,'b000,'b000,0,1);       // E35-E36
    add(1,0,1,0,0,0,'b011,'b011,0,1);                  // E37
    add(1,1,0,1,0,0,'b000,'b000,1,1);                  // E38 P=1 illegal
    add(1,0,0,0,0,0,'b000,'b000,0,1);                  // E39
    add(1,1,0,6,6,0,'b010,'b010,1,1);                  // E40 H=P illegal
    add(1,1,3,4,1,0,'b001,'b001,1,1);                  // E41 no such channel
    add(1,1,2,255,254,0,'b000,'b000,0,0);              // E42 max period, legal
    add(1,0,2,0,0,0,'b010,'b010,0,1);                  // E43 disabled ch applies
    repeat (7) add(0,0,0,0,0,0,'b010,'b000,0,1);       // E44-E50 frozen
    add(1,0,0,0,0,0,'b000,'b000,0,1);                  // E51 resume
    add(1,0,0,0,0,0,'b001,'b001,0,1);                  // E52
    add(1,0,0,0,0,0,'b010,'b010,0,1);                  // E53

    repeat (2) @(negedge clk);
    chk("reset clk_out", 32'(clk_out), 32'(0));
    chk("reset tick", 32'(tick), 32'(0));
    chk("reset cfg_err", 32'(cfg_if.cfg_err), 32'(0));
    chk("reset cfg_ready", 32'(cfg_if.cfg_ready), 32'(1));
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].en, 'b011, tbl[i].valid, tbl[i].ch, tbl[i].div, tbl[i].high, tbl[i].mode);
      chk($sformatf("row%0d clk_out", i + 1), 32'(clk_out), 32'(tbl[i].exp_clk));
      chk($sformatf("row%0d tick", i + 1), 32'(tick), 32'(tbl[i].exp_tick));
      chk($sformatf("row%0d cfg_err", i + 1), 32'(cfg_if.cfg_err), 32'(tbl[i].exp_err));
      chk($sformatf("row%0d cfg_ready", i + 1), 32'(cfg_if.cfg_ready), 32'(tbl[i].exp_rdy));
    end

    // ch0 at P4 H1; E55 is a ch0 wrap edge and also accepts P5 H2.
    cyc(1,'b011,0,0,0,0,0);                            // E54
    cyc(1,'b011,1,0,5,2,0);                            // E55
    chk("wrap_accept cfg_ready", 32'(cfg_if.cfg_ready), 32'(0));
    chk("wrap_accept cfg_err", 32'(cfg_if.cfg_err), 32'(0));
    exp_t = 10'b1000010001;
    exp_c = 10'b1000110001;
    for (int i = 0; i < 10; i++) begin                 // E56-E65
      cyc(1,'b011,0,0,0,0,0);
      chk($sformatf("late_apply tick0 c%0d", i), 32'(tick[0]), 32'(exp_t[i]));
      chk($sformatf("late_apply clk0 c%0d", i), 32'(clk_out[0]), 32'(exp_c[i]));
      if (i == 2) chk("late_apply ready before wrap", 32'(cfg_if.cfg_ready), 32'(0));
      if (i == 3) chk("late_apply ready at wrap", 32'(cfg_if.cfg_ready), 32'(1));
    end

    // Pending pulse-mode P3 is copied as soon as ch0 is disabled.
    cyc(1,'b011,1,0,3,1,1);                            // E66
    chk("dis_apply pending", 32'(cfg_if.cfg_ready), 32'(0));
    cyc(1,'b010,0,0,0,0,0);                            // E67
    chk("dis_apply clk0", 32'(clk_out[0]), 32'(0));
    chk("dis_apply tick0", 32'(tick[0]), 32'(0));
    chk("dis_apply ready", 32'(cfg_if.cfg_ready), 32'(1));
    exp_p = 4'b1001;
    for (int i = 0; i < 4; i++) begin                  // E68-E71
      cyc(1,'b011,0,0,0,0,0);
      chk($sformatf("dis_apply pulse tick0 c%0d", i), 32'(tick[0]), 32'(exp_p[i]));
      chk($sformatf("dis_apply pulse clk0 c%0d", i), 32'(clk_out[0]), 32'(exp_p[i]));
    end

    // Leave ch1 pending, then reset asynchronously mid-cycle.
    cyc(1,'b011,1,1,2,0,1);                            // E72
    chk("pre_reset pending ch1", 32'(cfg_if.cfg_ready), 32'(0));
    cfg_if.cfg_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset clk_out", 32'(clk_out), 32'(0));
    chk("async_reset tick", 32'(tick), 32'(0));
    chk("async_reset ready ch1", 32'(cfg_if.cfg_ready), 32'(1));
    repeat (2) @(negedge clk);
    chk("held_reset clk_out", 32'(clk_out), 32'(0));
    chk("held_reset cfg_err", 32'(cfg_if.cfg_err), 32'(0));
    rst_n = 1'b1;

    for (int k = 1; k <= 20; k++) begin
      cyc(1,'b011,0,1,0,0,0);
      e_clk  = (((k - 1) % 10) < 5) ? 3'b011 : 3'b000;
      e_tick = (((k - 1) % 10) == 0) ? 3'b011 : 3'b000;
      chk($sformatf("post_reset clk_out k%0d", k), 32'(clk_out), 32'(e_clk));
      chk($sformatf("post_reset tick k%0d", k), 32'(tick), 32'(e_tick));
    end
    chk("post_reset ready ch1", 32'(cfg_if.cfg_ready), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
